// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU with sticky overflow; optional SATURATE_EN clamps overflowed results
module alu_pipe #(
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [2:0]    opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out,
  output logic [2:0]    flags,
  input  logic          clr_sticky,
  output logic          ovf_sticky
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_INC  = 3'b101,
    OP_MOVA = 3'b110,
    OP_MOVB = 3'b111
  } op_t;

  logic          s1_valid;
  logic [BW-1:0] s1_a;
  logic [BW-1:0] s1_b;
  op_t           s1_op;

  logic          s1_adv;
  logic          s2_adv;

  logic [BW:0]   a_ext;
  logic [BW:0]   b_ext;
  logic [BW:0]   sum_ext;
  logic          is_arith;
  logic          ovf;
  logic [BW-1:0] res;
  logic [2:0]    flags_nxt;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= op_t'(opcode);
      end
    end
  end

  assign a_ext = {s1_a[BW-1], s1_a};
  assign b_ext = {s1_b[BW-1], s1_b};

  // With sign-extended operands, a BW+1 result whose top two bits differ
  // has left the BW-bit range; bit BW then carries the true sign.
  always_comb begin
    sum_ext  = '0;
    is_arith = 1'b0;
    res      = '0;
    case (s1_op)
      OP_ADD: begin
        sum_ext  = a_ext + b_ext;
        is_arith = 1'b1;
      end
      OP_SUB: begin
        sum_ext  = a_ext - b_ext;
        is_arith = 1'b1;
      end
      OP_INC: begin
        sum_ext  = a_ext + {{BW{1'b0}}, 1'b1};
        is_arith = 1'b1;
      end
      default: sum_ext = '0;
    endcase

    case (s1_op)
      OP_AND:  res = s1_a & s1_b;
      OP_OR:   res = s1_a | s1_b;
      OP_XOR:  res = s1_a ^ s1_b;
      OP_MOVA: res = s1_a;
      OP_MOVB: res = s1_b;
      default: res = sum_ext[BW-1:0];
    endcase

    ovf = is_arith && (sum_ext[BW] != sum_ext[BW-1]);

`ifdef SATURATE_EN
    if (ovf) begin
      res = sum_ext[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
    end
`endif

    flags_nxt = {ovf, res[BW-1], (res == '0)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= 3'b000;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out   <= res;
        flags <= flags_nxt;
      end
    end
  end

  // Set has priority over clear so a same-cycle overflow is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && flags[2]) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule
